bus_program_loader: RTL and testbench
=====================================

Name: bus_program_loader

Overview:
- Writer-side counterpart to the CPU's instruction fetch path.
- Receives a byte stream over a valid/ready handshake, assembles 16-bit words, and writes them into RAM through the shared bus starting at address 0.
- Holds the CPU (cpu_hold) for the whole load.
- Releases the CPU only when the trailing XOR checksum matches.

Parameters:
MAX_WORDS, 256, largest accepted program length in words; a length above this is an error.
ADDR_WIDTH, 16, width of load_address.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a load; sampled only in IDLE, DONE or ERROR
data_in  input  8  incoming byte
data_valid  input  1  data_in is valid
data_ready  output  1  loader can accept a byte
bus_out  output  16  word to place on the shared bus through a tristate buffer
bus_drive  output  1  enable for that tristate buffer
load_address  output  ADDR_WIDTH  RAM address; integration muxes it in while cpu_hold=1
wr_enable  output  1  RAM write strobe
cpu_hold  output  1  stalls control unit and PC
done  output  1  load completed with a good checksum
error  output  1  load aborted
words_loaded  output  16  count of words written in the current/last load

Behaviour:
- Reset: state=IDLE. All outputs 0, including data_ready, cpu_hold, done, error, words_loaded and load_address. Internal length, checksum and byte latch are cleared.
- Byte handshake: a byte is accepted on a rising edge where data_valid && data_ready.
  - data_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI, SUM_LO.
  - Every word is sent high byte first.
- Frame format: length word N, then N data words, then a checksum word equal to the XOR of all N data words.
- IDLE/DONE/ERROR + start=1:
  - Go to LEN_HI.
  - Set cpu_hold=1; clear done, error, words_loaded, checksum and address.
  - start in any other state is ignored.
- LEN_HI -> LEN_LO -> LEN_CHK: advance on each accepted byte.
- LEN_CHK (1 cycle):
  - N>MAX_WORDS -> ERROR.
  - N=0 -> SUM_HI.
  - Otherwise -> DATA_HI.
- DATA_HI -> DATA_LO -> WRITE.
- WRITE (exactly 1 cycle):
  - Outputs: bus_drive=1, wr_enable=1, bus_out=assembled word, load_address=current address, data_ready=0.
  - On exit: checksum ^= word; address and words_loaded increment by 1.
  - Next state: SUM_HI if words_loaded+1==N, else DATA_HI.
- Latency: the low-byte accept edge at cycle k gives the write strobe during cycle k+1. Sustained rate is 3 cycles per word.
- SUM_HI -> SUM_LO -> CHECK.
- CHECK (1 cycle): received sum == checksum -> DONE, else -> ERROR.
- DONE: cpu_hold=0, done=1. Held until the next start or rst.
- ERROR: error=1, cpu_hold stays 1 (CPU never runs a bad image). Held until start or rst.
- bus_drive and wr_enable are 1 only in WRITE. The loader never drives the bus otherwise, so there is no contention with CPU buffers.
- data_valid gaps of any length stall the FSM with no state change. data_valid while data_ready=0 has no effect.
- rst mid-load: return to IDLE next edge and deassert everything, including cpu_hold. Partially written RAM is not cleared.
- load_address wraps naturally at 2^ADDR_WIDTH; this is unreachable when MAX_WORDS < 2^ADDR_WIDTH.

Test Plan:
- Two-word load. Stream 00 02 12 34 AB CD B9 F9 with valid held high.
  - Expect writes 0x1234 @0 then 0xABCD @1, each as a single-cycle wr_enable with bus_drive=1.
  - Then done=1, cpu_hold=0, words_loaded=2.
- Zero length. Stream 00 00 00 00.
  - Expect no wr_enable pulse, done=1, words_loaded=0.
- Bad checksum. Same frame as the two-word load but sum FF FF.
  - Expect both writes to occur, then error=1, done=0, cpu_hold=1.
- Length overflow with MAX_WORDS=4. Stream 00 05.
  - Expect ERROR right after LEN_CHK, no writes, and data_ready=0.
- Handshake gaps and ignored start. Repeat the two-word load with data_valid toggling randomly, and pulse start mid-load.
  - Expect identical writes and done; the extra start has no effect.
- Reset mid-load. Assert rst after the first WRITE.
  - Expect all outputs 0 next cycle.
  - A fresh start plus a full frame then loads correctly from address 0.

Source files
------------

// File: rtl/bus_program_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first), writes them to RAM
// from address 0 over the shared bus, and keeps the CPU held unless the XOR checksum matches.
module bus_program_loader #(
  parameter int MAX_WORDS  = 256,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [15:0]           bus_out,
  output logic                  bus_drive,
  output logic [ADDR_WIDTH-1:0] load_address,
  output logic                  wr_enable,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded,
  output logic [3:0]            state_dbg
);

  // Handshake: a byte transfers on a rising edge where data_valid && data_ready;
  // data_ready depends only on the current state, never on data_valid.
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_LEN_CHK, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_SUM_HI, S_SUM_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           sum_q, sum_d;
  logic [7:0]            byte_q, byte_d;
  logic [15:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           count_q, count_d;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    data_ready = 1'b0;
    wr_enable  = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_SUM_HI, S_SUM_LO: data_ready = 1'b1;
      S_WRITE:                                                      wr_enable  = 1'b1;
      default: ;
    endcase
  end

  assign accept       = data_valid && data_ready;
  assign bus_drive    = wr_enable;
  assign bus_out      = wr_enable ? word_q : 16'h0000;
  assign load_address = addr_q;
  assign words_loaded = count_q;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_hold     = !(state_q == S_IDLE || state_q == S_DONE);
  assign state_dbg    = state_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          sum_d   = '0;
          addr_d  = '0;
          count_d = '0;
        end
      end
      S_LEN_HI: if (accept) begin byte_d = data_in; state_d = S_LEN_LO; end
      S_LEN_LO: if (accept) begin len_d = {byte_q, data_in}; state_d = S_LEN_CHK; end
      S_LEN_CHK: begin
        if ({1'b0, len_q} > MAX_W) state_d = S_ERROR;
        else if (len_q == 16'd0)   state_d = S_SUM_HI;
        else                       state_d = S_DATA_HI;
      end
      S_DATA_HI: if (accept) begin byte_d = data_in; state_d = S_DATA_LO; end
      S_DATA_LO: if (accept) begin word_d = {byte_q, data_in}; state_d = S_WRITE; end
      S_WRITE: begin
        sum_d   = sum_q ^ word_q;
        addr_d  = addr_q + ADDR_WIDTH'(1);
        count_d = count_q + 16'd1;
        state_d = (count_q + 16'd1 == len_q) ? S_SUM_HI : S_DATA_HI;
      end
      S_SUM_HI: if (accept) begin byte_d = data_in; state_d = S_SUM_LO; end
      // The received checksum reuses the word register; it is compared in CHECK.
      S_SUM_LO: if (accept) begin word_d = {byte_q, data_in}; state_d = S_CHECK; end
      S_CHECK: state_d = (word_q == sum_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_program_loader.sv
// Bench for bus_program_loader: table of whole frames plus hand-written sequences for
// handshake gaps, ignored start and reset mid-load.
module tb_bus_program_loader;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst, start, data_valid;
  logic [7:0]  data_in;
  logic        data_ready, bus_drive, wr_enable, cpu_hold, done, error;
  logic [15:0] bus_out, load_address, words_loaded;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  bus_program_loader #(.MAX_WORDS(MAXW), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .bus_out(bus_out), .bus_drive(bus_drive),
    .load_address(load_address), .wr_enable(wr_enable), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [95:0] bytes;     // byte i at [95-8*i -: 8]
    logic [7:0]  nb;
    logic [63:0] words;     // expected write i at [63-16*i -: 16]
    logic [7:0]  nw;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs[6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc++;

  // Write monitor: bus_drive must track wr_enable, and strobes are single-cycle.
  always @(negedge clk) begin
    checks++;
    if (bus_drive !== wr_enable) begin
      errors++;
      $display("FAIL bus_drive_vs_wr_enable got=%0b exp=%0b", bus_drive, wr_enable);
    end
    if (wr_enable) begin
      got_q.push_back({load_address, bus_out});
      got_cyc.push_back(cyc);
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL wr_enable_single_cycle got=two_cycles exp=one_cycle");
      end
    end
    prev_wr = wr_enable;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("words_cleared", {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        data_valid = 1'b0;
        @(negedge clk);
      end
    end
    data_in = b;
    data_valid = 1'b1;
    n = 0;
    while (!data_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!data_ready) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("end_timeout", {31'd0, (done || error)}, 32'd1);
  endtask

  task automatic check_writes(input string name, input logic [63:0] words, input int nw,
                              input bit rate);
    logic [31:0] e, g;
    for (int i = 0; i < nw; i++) exp_q.push_back({16'(i), words[63-16*i -: 16]});
    check({name, "_nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < nw && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, "_write"}, g, e);
      if (rate && i > 0) check({name, "_rate"}, got_cyc[i] - got_cyc[i-1], 32'd3);
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, {31'd0, data_ready}, 32'd0);
    check({name, "_hold"},  {31'd0, cpu_hold},   32'd0);
    check({name, "_done"},  {31'd0, done},       32'd0);
    check({name, "_error"}, {31'd0, error},      32'd0);
    check({name, "_words"}, {16'd0, words_loaded}, 32'd0);
    check({name, "_addr"},  {16'd0, load_address}, 32'd0);
    check({name, "_wr"},    {30'd0, wr_enable, bus_drive}, 32'd0);
    check({name, "_bus"},   {16'd0, bus_out},    32'd0);
    check({name, "_state"}, {28'd0, state_dbg},  32'd0);
  endtask

  task automatic run_vec(input int k, input bit gaps, input bit mid_start);
    vec_t v;
    v = vecs[k];
    got_q.delete();
    got_cyc.delete();
    do_start();
    for (int i = 0; i < 32'(v.nb); i++) begin
      if (mid_start && i == 4) begin
        data_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(v.bytes[95-8*i -: 8], gaps);
    end
    data_valid = 1'b0;
    wait_end();
    check($sformatf("v%0d_done", k),  {31'd0, done},  {31'd0, v.exp_done});
    check($sformatf("v%0d_error", k), {31'd0, error}, {31'd0, v.exp_err});
    check($sformatf("v%0d_hold", k),  {31'd0, cpu_hold}, {31'd0, v.exp_err});
    check($sformatf("v%0d_words", k), {16'd0, words_loaded}, {16'd0, v.exp_words});
    check($sformatf("v%0d_ready", k), {31'd0, data_ready}, 32'd0);
    check_writes($sformatf("v%0d", k), v.words, 32'(v.nw), !gaps);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    // two-word load
    vecs[0] = '{bytes: {64'h0002_1234_ABCD_B9F9, 32'h0}, nb: 8, words: {32'h1234_ABCD, 32'h0},
                nw: 2, exp_done: 1, exp_err: 0, exp_words: 2};
    // zero length
    vecs[1] = '{bytes: {32'h0000_0000, 64'h0}, nb: 4, words: 64'h0,
                nw: 0, exp_done: 1, exp_err: 0, exp_words: 0};
    // bad checksum
    vecs[2] = '{bytes: {64'h0002_1234_ABCD_FFFF, 32'h0}, nb: 8, words: {32'h1234_ABCD, 32'h0},
                nw: 2, exp_done: 0, exp_err: 1, exp_words: 2};
    // length above MAX_WORDS
    vecs[3] = '{bytes: {16'h0005, 80'h0}, nb: 2, words: 64'h0,
                nw: 0, exp_done: 0, exp_err: 1, exp_words: 0};
    // length exactly MAX_WORDS is accepted
    vecs[4] = '{bytes: 96'h0004_0001_0002_0004_0008_000F, nb: 12,
                words: 64'h0001_0002_0004_0008, nw: 4, exp_done: 1, exp_err: 0, exp_words: 4};
    // one word
    vecs[5] = '{bytes: {48'h0001_BEEF_BEEF, 48'h0}, nb: 6, words: {16'hBEEF, 48'h0},
                nw: 1, exp_done: 1, exp_err: 0, exp_words: 1};

    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");

    for (int k = 0; k < 6; k++) run_vec(k, 1'b0, 1'b0);

    // Random data_valid gaps and a start pulse in the middle of the frame.
    run_vec(0, 1'b1, 1'b1);

    // Reset after the first write, then a full reload from address 0.
    got_q.delete();
    got_cyc.delete();
    do_start();
    for (int i = 0; i < 4; i++) send_byte(vecs[0].bytes[95-8*i -: 8], 1'b0);
    data_valid = 1'b0;
    n = 0;
    while (got_q.size() == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_write_seen", got_q.size(), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_load");
    rst = 1'b0;
    @(negedge clk);
    run_vec(0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
